fft8_result_serializer: RTL and testbench

Downstream stage of the 8-point FFT core. Captures each parallel result frame (8 complex bins) on the core's result-valid pulse, buffers whole frames in a small frame FIFO, and streams bins out one per cycle over a valid/ready handshake with bin index and last-bin flag. The FFT pipeline cannot stall, so frames that arrive while the buffer is full are dropped and counted.

---
 rtl/fft8_result_serializer_if.sv | 11 +
 rtl/fft8_result_serializer.sv | 77 +++++++
 tb/tb_fft8_result_serializer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fft8_result_serializer_if.sv
// fft8_result_serializer_if: bin stream from the serializer to its consumer
interface fft8_result_serializer_if #(parameter int W = 16);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic [2:0]   out_index;
    logic         out_last;
    modport master (output out_valid, out_re, out_im, out_index, out_last, input out_ready);
    modport slave  (input out_valid, out_re, out_im, out_index, out_last, output out_ready);
endinterface

// File: rtl/fft8_result_serializer.sv
// fft8_result_serializer: buffers whole FFT result frames and streams them out bin by bin
module fft8_result_serializer #(
    parameter int INT_SIZE  = 8,
    parameter int FRAC_SIZE = 8,
    parameter int FRAMES    = 2,
    localparam int W        = INT_SIZE + FRAC_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      result_valid,
    input  logic [8*W-1:0]            in_re,
    input  logic [8*W-1:0]            in_im,
    fft8_result_serializer_if.master  os,
    output logic                      overflow,
    input  logic                      clear_overflow,
    output logic [7:0]                drop_count
);
    localparam int PW = $clog2(FRAMES);
    localparam int CW = $clog2(FRAMES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAMES);
    typedef enum logic [1:0] {EMPTY, STREAMING, FULL} state_t;
    state_t        state;
    logic [W-1:0]  mem_re [FRAMES*8];
    logic [W-1:0]  mem_im [FRAMES*8];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx;
    logic          valid, pop, pop_last, accept, drop;
    always_comb begin
        valid    = state != EMPTY;
        pop      = valid & os.out_ready;
        pop_last = pop & (idx == 3'd7);
        // a full buffer still takes a frame when the head frame leaves on this edge
        accept   = result_valid & ((cnt != FULL_CNT) | pop_last);
        drop     = result_valid & ~accept;
        cnt_n    = cnt + CW'(accept) - CW'(pop_last);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            cnt        <= '0;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cnt   <= cnt_n;
            state <= cnt_n == '0 ? EMPTY : cnt_n == FULL_CNT ? FULL : STREAMING;
            if (pop) idx <= idx + 3'd1;
            if (pop_last) rd_ptr <= rd_ptr + PW'(1);
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clear_overflow ? 8'd1 : drop_count + {7'd0, drop_count != 8'hff};
            end else if (clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                mem_re[{wr_ptr, 3'(k)}] <= in_re[k*W +: W];
                mem_im[{wr_ptr, 3'(k)}] <= in_im[k*W +: W];
            end
        end
    end
    always_comb begin
        os.out_valid = valid;
        os.out_re    = valid ? mem_re[{rd_ptr, idx}] : '0;
        os.out_im    = valid ? mem_im[{rd_ptr, idx}] : '0;
        os.out_index = idx;
        os.out_last  = idx == 3'd7;
    end
endmodule

// File: tb/tb_fft8_result_serializer.sv
// tb_fft8_result_serializer: table vectors, corner sequences and a queue-based frame model
module tb_fft8_result_serializer;
    localparam int FRAMES = 2;
    typedef struct packed {
        logic [127:0] re;
        logic [127:0] im;
    } frame_t;
    typedef struct packed {
        logic        rv;
        logic        rdy;
        logic        v;
        logic [2:0]  ix;
        logic        l;
        logic [15:0] re;
        logic [15:0] im;
    } vec_t;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         result_valid = 0;
    logic [127:0] in_re = '0;
    logic [127:0] in_im = '0;
    logic         clear_overflow = 0;
    logic         overflow;
    logic [7:0]   drop_count;
    int           checks = 0;
    int           errors = 0;
    frame_t       q[$];
    int           m_idx = 0;
    bit           m_ovf = 0;
    int           m_drops = 0;
    vec_t         tbl[10];
    frame_t       f0, f1, f2, f3;
    fft8_result_serializer_if #(.W(16)) bus();
    fft8_result_serializer #(.INT_SIZE(8), .FRAC_SIZE(8), .FRAMES(FRAMES)) dut (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .in_re(in_re), .in_im(in_im),
        .os(bus.master), .overflow(overflow), .clear_overflow(clear_overflow), .drop_count(drop_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask
    function automatic frame_t rnd_frame();
        frame_t f;
        for (int k = 0; k < 8; k++) begin
            f.re[k*16 +: 16] = 16'($urandom);
            f.im[k*16 +: 16] = 16'($urandom);
        end
        return f;
    endfunction
    task automatic check_model();
        chk("valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("re", {16'd0, bus.out_re}, {16'd0, q[0].re[m_idx*16 +: 16]});
            chk("im", {16'd0, bus.out_im}, {16'd0, q[0].im[m_idx*16 +: 16]});
            chk("index", {29'd0, bus.out_index}, 32'(m_idx));
            chk("last", {31'd0, bus.out_last}, {31'd0, m_idx == 7});
        end
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_count", {24'd0, drop_count}, 32'(m_drops));
    endtask
    task automatic model_update();
        bit pop, pl, acc;
        pop = q.size() != 0 && bus.out_ready;
        pl  = pop && m_idx == 7;
        acc = result_valid && (q.size() < FRAMES || pl);
        if (pop) m_idx++;
        if (pl) begin
            void'(q.pop_front());
            m_idx = 0;
        end
        if (result_valid && !acc) begin
            m_ovf = 1;
            m_drops = clear_overflow ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
        end else if (clear_overflow) begin
            m_ovf = 0;
            m_drops = 0;
        end
        if (acc) q.push_back('{re: in_re, im: in_im});
    endtask
    task automatic drive(input logic rv, input logic rdy, input logic clr, input frame_t fr);
        result_valid = rv;
        bus.out_ready = rdy;
        clear_overflow = clr;
        in_re = fr.re;
        in_im = fr.im;
        #1 check_model();
    endtask
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask
    task automatic step(input logic rv, input logic rdy, input logic clr, input frame_t fr);
        drive(rv, rdy, clr, fr);
        tick();
    endtask
    task automatic model_reset();
        q.delete();
        m_idx = 0;
        m_ovf = 0;
        m_drops = 0;
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_re"}, {16'd0, bus.out_re}, 32'd0);
        chk({tag, "_im"}, {16'd0, bus.out_im}, 32'd0);
        chk({tag, "_index"}, {29'd0, bus.out_index}, 32'd0);
        chk({tag, "_last"}, {31'd0, bus.out_last}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_drops"}, {24'd0, drop_count}, 32'd0);
    endtask
    initial begin
        bus.out_ready = 0;
        for (int k = 0; k < 8; k++) begin
            f0.re[k*16 +: 16] = 16'(16'h0100 * (k + 1));
            f0.im[k*16 +: 16] = 16'(-k);
        end
        tbl[0] = '{rv: 1, rdy: 1, v: 0, ix: 0, l: 0, re: 0, im: 0};
        for (int c = 1; c <= 8; c++)
            tbl[c] = '{rv: 0, rdy: 1, v: 1, ix: 3'(c - 1), l: c == 8, re: 16'(16'h0100 * c), im: 16'(-(c - 1))};
        tbl[9] = '{rv: 0, rdy: 1, v: 0, ix: 0, l: 0, re: 0, im: 0};
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rv, tbl[i].rdy, 0, f0);
            chk("tbl_valid", {31'd0, bus.out_valid}, {31'd0, tbl[i].v});
            if (tbl[i].v) begin
                chk("tbl_index", {29'd0, bus.out_index}, {29'd0, tbl[i].ix});
                chk("tbl_last", {31'd0, bus.out_last}, {31'd0, tbl[i].l});
                chk("tbl_re", {16'd0, bus.out_re}, {16'd0, tbl[i].re});
                chk("tbl_im", {16'd0, bus.out_im}, {16'd0, tbl[i].im});
            end
            tick();
        end
        f1 = rnd_frame();
        step(1, 0, 0, f1);
        for (int i = 0; i < 40; i++) step(0, i % 3 == 0, 0, f1);
        chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);
        f1 = rnd_frame();
        f2 = rnd_frame();
        f3 = rnd_frame();
        step(1, 0, 0, f1);
        step(0, 0, 0, f1);
        step(1, 0, 0, f2);
        step(0, 0, 0, f2);
        step(1, 0, 0, f3);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {24'd0, drop_count}, 32'd1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, f3);
        step(0, 1, 1, f3);
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        chk("ovf_clear_count", {24'd0, drop_count}, 32'd0);
        f1 = rnd_frame();
        f2 = rnd_frame();
        f3 = rnd_frame();
        step(1, 0, 0, f1);
        step(1, 0, 0, f2);
        for (int i = 0; i < 7; i++) step(0, 1, 0, f3);
        chk("fp_last", {31'd0, bus.out_last}, 32'd1);
        step(1, 1, 0, f3);
        chk("fp_nodrop", {24'd0, drop_count}, 32'd0);
        chk("fp_ovf", {31'd0, overflow}, 32'd0);
        chk("fp_qlen", 32'(q.size()), 32'd2);
        for (int i = 0; i < 20; i++) step(0, 1, 0, f3);
        step(1, 0, 0, f1);
        step(1, 0, 0, f2);
        for (int i = 0; i < 300; i++) step(1, 0, 0, rnd_frame());
        chk("sat_count", {24'd0, drop_count}, 32'd255);
        step(1, 0, 1, f3);
        chk("drop_beats_clear", {24'd0, drop_count}, 32'd1);
        chk("drop_beats_clear_ovf", {31'd0, overflow}, 32'd1);
        step(0, 0, 1, f3);
        for (int i = 0; i < 20; i++) step(0, 1, 0, f3);
        f1 = rnd_frame();
        step(1, 1, 0, f1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, f1);
        chk("mid_index", {29'd0, bus.out_index}, 32'd4);
        rst_n = 0;
        result_valid = 0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        step(0, 1, 0, f1);
        f2 = rnd_frame();
        step(1, 1, 0, f2);
        chk("post_rst_index", {29'd0, bus.out_index}, 32'd0);
        chk("post_rst_re", {16'd0, bus.out_re}, {16'd0, f2.re[15:0]});
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, rnd_frame());
        for (int i = 0; i < 30; i++) step(0, 1, 0, f0);
        chk("final_empty", {31'd0, bus.out_valid}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
